// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_pkg
// Purpose  : Shared constants for the cache memory-port arbiter: FSM state
//            encoding and the transfer-size encoding of the memory port.
// Revision : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

  // Arbiter FSM state encoding
  typedef logic [0:0] arb_state_t;
  localparam arb_state_t ST_IDLE = 1'b0;
  localparam arb_state_t ST_BUSY = 1'b1;

  // Transfer-size encoding on the memory port
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

endpackage : mem_port_arbiter_pkg
`default_nettype wire

// File: rtl/mem_port_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational request picker. With rr_en_i set, the winner is
//            the first requester at or after ptr_i (wrapping upward); with
//            rr_en_i clear, the lowest-index requester wins.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int N_PORTS = 2,
  parameter int GID_W   = $clog2(N_PORTS)
) (
  input  logic [N_PORTS-1:0] req_i,
  input  logic [GID_W-1:0]   ptr_i,
  input  logic               rr_en_i,
  output logic [GID_W-1:0]   gnt_o,
  output logic               valid_o
);

  // Scan the requesters starting from the search origin, taking the first hit
  always_comb begin
    int start;
    int idx;
    gnt_o   = '0;
    valid_o = 1'b0;
    start   = rr_en_i ? int'(ptr_i) : 0;
    // An out-of-range pointer can only come from a corrupted register;
    // fall back to a plain lowest-index search.
    if (start >= N_PORTS) begin
      start = 0;
    end
    idx = 0;
    for (int k = 0; k < N_PORTS; k++) begin
      idx = start + k;
      if (idx >= N_PORTS) begin
        idx = idx - N_PORTS;
      end
      if (!valid_o && req_i[idx]) begin
        valid_o = 1'b1;
        gnt_o   = GID_W'(idx);
      end
    end
  end

endmodule : rr_pick
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : N-port arbiter in front of the AXI bridge. Grants one cache
//            client at a time (fixed priority or round-robin), latches its
//            request and holds the grant until the final beat completes.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int N_PORTS = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 4,
  parameter int RR_EN   = 1,
  parameter int GID_W   = $clog2(N_PORTS)
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [N_PORTS-1:0]        p_access,
  input  logic [N_PORTS-1:0]        p_write,
  input  logic [N_PORTS*ADDR_W-1:0] p_a,
  input  logic [N_PORTS*2-1:0]      p_size,
  input  logic [N_PORTS*4-1:0]      p_sel,
  input  logic [N_PORTS*LEN_W-1:0]  p_len,
  input  logic [N_PORTS*DATA_W-1:0] p_st_data,
  output logic [N_PORTS-1:0]        p_ready,
  output logic [DATA_W-1:0]         p_data,
  output logic                      mem_access,
  output logic                      mem_write,
  output logic [ADDR_W-1:0]         mem_a,
  output logic [1:0]                mem_size,
  output logic [3:0]                mem_sel,
  output logic [LEN_W-1:0]          mem_len,
  output logic [DATA_W-1:0]         mem_st_data,
  input  logic [DATA_W-1:0]         mem_data,
  input  logic                      mem_ready,
  output logic                      busy,
  output logic [GID_W-1:0]          grant_id
);

  // Per-client views of the packed request buses
  logic [ADDR_W-1:0] a_arr    [N_PORTS];
  logic [1:0]        size_arr [N_PORTS];
  logic [3:0]        sel_arr  [N_PORTS];
  logic [LEN_W-1:0]  len_arr  [N_PORTS];
  logic [DATA_W-1:0] st_arr   [N_PORTS];

  // FSM, grant and latched-request registers
  arb_state_t        state_q,    state_d;
  logic [GID_W-1:0]  grant_q,    grant_d;
  logic [GID_W-1:0]  rr_ptr_q,   rr_ptr_d;
  logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic              wr_q,       wr_d;
  logic [ADDR_W-1:0] a_q,        a_d;
  logic [1:0]        size_q,     size_d;
  logic [3:0]        sel_q,      sel_d;
  logic [LEN_W-1:0]  len_q,      len_d;
  logic [DATA_W-1:0] st_data_q,  st_data_d;

  logic [GID_W-1:0]  pick_idx;
  logic              pick_valid;
  logic              in_busy;

  assign in_busy = (state_q == ST_BUSY);

  generate
    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_port
      assign a_arr[gi]    = p_a[gi*ADDR_W +: ADDR_W];
      assign size_arr[gi] = p_size[gi*2 +: 2];
      assign sel_arr[gi]  = p_sel[gi*4 +: 4];
      assign len_arr[gi]  = p_len[gi*LEN_W +: LEN_W];
      assign st_arr[gi]   = p_st_data[gi*DATA_W +: DATA_W];
      // Beat completion is steered only to the client holding the grant
      assign p_ready[gi]  = mem_ready & in_busy & (grant_q == GID_W'(gi));
    end
  endgenerate

  rr_pick #(
    .N_PORTS (N_PORTS),
    .GID_W   (GID_W)
  ) u_pick (
    .req_i   (p_access),
    .ptr_i   (rr_ptr_q),
    .rr_en_i (RR_EN != 0),
    .gnt_o   (pick_idx),
    .valid_o (pick_valid)
  );

  // Next-state: arbitrate in IDLE, count beats in BUSY
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    wr_d       = wr_q;
    a_d        = a_q;
    size_d     = size_q;
    sel_d      = sel_q;
    len_d      = len_q;
    st_data_d  = st_data_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d    = ST_BUSY;
          grant_d    = pick_idx;
          wr_d       = p_write[pick_idx];
          a_d        = a_arr[pick_idx];
          size_d     = size_arr[pick_idx];
          sel_d      = sel_arr[pick_idx];
          st_data_d  = st_arr[pick_idx];
          // Stores are always single-beat regardless of the len field
          len_d      = p_write[pick_idx] ? '0 : len_arr[pick_idx];
          beat_cnt_d = len_d;
        end
      end
      ST_BUSY: begin
        if (mem_ready) begin
          if (beat_cnt_q == '0) begin
            state_d  = ST_IDLE;
            rr_ptr_d = (grant_q == GID_W'(N_PORTS - 1)) ? '0 : grant_q + 1'b1;
          end else begin
            beat_cnt_d = beat_cnt_q - 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset clears the in-flight transaction immediately
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      wr_q       <= 1'b0;
      a_q        <= '0;
      size_q     <= '0;
      sel_q      <= '0;
      len_q      <= '0;
      st_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      wr_q       <= wr_d;
      a_q        <= a_d;
      size_q     <= size_d;
      sel_q      <= sel_d;
      len_q      <= len_d;
      st_data_q  <= st_data_d;
    end
  end

  assign mem_access  = in_busy;
  assign busy        = in_busy;
  assign grant_id    = grant_q;
  assign mem_write   = wr_q;
  assign mem_a       = a_q;
  assign mem_size    = size_q;
  assign mem_sel     = sel_q;
  assign mem_len     = len_q;
  assign mem_st_data = st_data_q;
  assign p_data      = mem_data;

endmodule : mem_port_arbiter
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Parametrised N-port arbiter that replaces the combinational icache/dcache select in front of `axi_interface`. Each cache-side client presents a single-beat or read-burst request on the cache memory-port protocol. The arbiter grants one client at a time under fixed-priority or round-robin policy, latches the request, and holds the grant until the last beat completes. `mem_ready` is routed back only to the granted client.

## Interface
- `N_PORTS`, 2: number of clients, 2..8.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `LEN_W`, 4: burst-length field width; beats = len+1.
- `RR_EN`, 1: 1 = round-robin; 0 = fixed priority, port 0 highest.
- `GID_W`, $clog2(N_PORTS): grant index width.

Ports (`clk`, `resetn` first):
- `clk`  in  1  single clock.
- `resetn`  in  1  reset; asynchronous, active-low.
- `p_access`  in  N_PORTS  per-client request valid.
- `p_write`  in  N_PORTS  1 = store.
- `p_a`  in  N_PORTS*ADDR_W  request address.
- `p_size`  in  N_PORTS*2  transfer size.
- `p_sel`  in  N_PORTS*4  byte strobes.
- `p_len`  in  N_PORTS*LEN_W  beats-1; forced to 0 when `p_write`=1.
- `p_st_data`  in  N_PORTS*DATA_W  store data.
- `p_ready`  out  N_PORTS  per-client beat done.
- `p_data`  out  DATA_W  read data, broadcast to all clients.
- `mem_access`  out  1  request to `axi_interface`.
- `mem_write`  out  1  store request.
- `mem_a`  out  ADDR_W  request address.
- `mem_size`  out  2  transfer size.
- `mem_sel`  out  4  byte strobes.
- `mem_len`  out  LEN_W  burst length field.
- `mem_st_data`  out  DATA_W  store data.
- `mem_data`  in  DATA_W  read data from `axi_interface`.
- `mem_ready`  in  1  beat complete.
- `busy`  out  1  transaction in flight.
- `grant_id`  out  GID_W  index of the granted client.

## Operation
- FSM has two states.
  - IDLE: if any `p_access` bit is set, select winner g, latch g's a/write/size/sel/len/st_data, load `beat_cnt` = len (0 when write), go to BUSY. Otherwise stay in IDLE.
  - BUSY: `mem_access`=1 and the mem_* outputs come from the latched registers. On each `mem_ready`, pulse `p_ready[g]`; if `beat_cnt`==0, go to IDLE, otherwise decrement `beat_cnt`.
- Fixed-priority policy (RR_EN=0): winner is the lowest-index requester.
- Round-robin policy (RR_EN=1): winner is the first requester at or after `rr_ptr`, searching upward with wrap-around. On transaction completion, `rr_ptr` = (g+1) mod N_PORTS.
- Clients hold `p_access` until their final `p_ready`. Changes to the request after the grant are ignored because the request is latched.
- Dropping `p_access` while BUSY does not abort; the transaction runs to completion.
- `p_ready[i]` = `mem_ready` & BUSY & (g==i). `p_data` = `mem_data`, combinational.
- `mem_ready` in IDLE is ignored and produces no `p_ready`.
- A client re-requesting after completion goes back through arbitration. Under round-robin, another requester wins first.

## Timing
- Reset values: state IDLE, `mem_access`=0, all mem_* registers 0, `p_ready`=0, `busy`=0, `grant_id`=0, `rr_ptr`=0, `beat_cnt`=0.
- Reset asserted mid-transaction clears everything immediately; the downstream bridge is reset by the same `resetn`.
- Grant latency: `p_access` seen at edge k gives `mem_access` high from cycle k+1.
- Handover: the last `mem_ready` at edge m drops `mem_access` at cycle m+1 (IDLE). The next grant is issued at m+1 and `mem_access` rises at m+2. This leaves exactly one idle bubble between transactions.
- `p_ready` has zero latency from `mem_ready`.
- `busy` equals BUSY state. `grant_id` is registered and valid while `busy`=1.

## Structure
- Shared package: state enum (IDLE/BUSY) and size encoding constants (byte 2'b00, half 2'b01, word 2'b10).
- Sub-module `rr_pick`: combinational priority picker with inputs req[N_PORTS], ptr[GID_W], rr_en, and outputs grant index and valid.
- Top instantiates `mem_port_arbiter` with N_PORTS=2, port 0 = icache, port 1 = dcache.

## Test plan
- Single request: port1 read, a=0x1FC0_0010, len=0; `mem_ready` 3 cycles later -> `mem_access` high cycles 1-3; one `p_ready[1]` pulse; `p_data` = `mem_data` = 0xDEADBEEF.
- Burst: port0 len=7 -> exactly 8 `p_ready[0]` pulses; `mem_len`=7 throughout; IDLE after the 8th pulse.
- Collision, RR_EN=1: both ports request continuously from reset -> grant order 0,1,0,1 with one bubble cycle between transactions.
- Collision, RR_EN=0: both ports request continuously -> port 0 wins every arbitration; port 1 is never granted.
- Write with `p_len`=5 -> `mem_len`=0 and a single beat; `mem_st_data`/`mem_sel` hold the values latched at grant even if the client changes them afterward.
- `resetn` pulled low during beat 3 of an 8-beat burst -> all outputs return to their reset values asynchronously; after release a new port1 request is granted, with `rr_ptr` back at 0.
